// File: rtl/memory_stage.sv
// Memory stage: drives the data memory port and holds the M/W pipeline register.
// Zero-wait access completes in one cycle; a missing DMemAck stalls upstream and bubbles into W.
module memory_stage (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,
    input  logic [4:0]  RdM,
    input  logic [3:0]  controlM,
    input  logic [31:0] DMemRData,
    input  logic        DMemAck,
    output logic        DMemReq,
    output logic        DMemWE,
    output logic [31:0] DMemAddr,
    output logic [31:0] DMemWData,
    output logic        StallM,
    output logic [31:0] ALUResultMH,
    output logic [4:0]  RdMH,
    output logic        RegWriteMH,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
    output logic [4:0]  RdW,
    output logic [2:0]  controlW,
    output logic [15:0] StallCount
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        access, load, store;

    logic [31:0] alu_result_w_q, alu_result_w_d;
    logic [31:0] read_data_w_q, read_data_w_d;
    logic [31:0] pc_plus4_w_q, pc_plus4_w_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic [2:0]  control_w_q, control_w_d;
    logic [15:0] stall_count_q, stall_count_d;

    assign access = controlM[0] | (controlM[2:1] == 2'b01);
    assign load   = (controlM[2:1] == 2'b01) & ~controlM[0];
    assign store  = controlM[0];

    assign DMemAddr    = ALUResultM;
    assign DMemWData   = WriteDataM;
    assign DMemWE      = store;
    assign ALUResultMH = ALUResultM;
    assign RdMH        = RdM;
    assign RegWriteMH  = controlM[3];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // An ack without an access is a stray strobe and must not move the FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (access && !DMemAck) state_d = ST_WAIT;
            ST_WAIT: if (access && DMemAck)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request stays up in both states so a zero-wait memory never stalls.
    always_comb begin
        DMemReq = access & ~RST;
        StallM  = access & ~DMemAck & ~RST;
    end

    always_comb begin
        alu_result_w_d = ALUResultM;
        read_data_w_d  = load ? DMemRData : 32'h0;
        pc_plus4_w_d   = PCPlus4M;
        rd_w_d         = RdM;
        control_w_d    = controlM[3:1];
        stall_count_d  = stall_count_q;
        if (StallM) begin
            alu_result_w_d = 32'h0;
            read_data_w_d  = 32'h0;
            pc_plus4_w_d   = 32'h0;
            rd_w_d         = 5'd0;
            control_w_d    = 3'b000;
            if (stall_count_q != 16'hFFFF) begin
                stall_count_d = stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            alu_result_w_q <= 32'h0;
            read_data_w_q  <= 32'h0;
            pc_plus4_w_q   <= 32'h0;
            rd_w_q         <= 5'd0;
            control_w_q    <= 3'b000;
            stall_count_q  <= 16'h0;
        end else begin
            alu_result_w_q <= alu_result_w_d;
            read_data_w_q  <= read_data_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            rd_w_q         <= rd_w_d;
            control_w_q    <= control_w_d;
            stall_count_q  <= stall_count_d;
        end
    end

    assign ALUResultW = alu_result_w_q;
    assign ReadDataW  = read_data_w_q;
    assign PCPlus4W   = pc_plus4_w_q;
    assign RdW        = rd_w_q;
    assign controlW   = control_w_q;
    assign StallCount = stall_count_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table, hand-written multi-cycle sequences, random run vs. model.
module tb_memory_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] ALUResultM = '0, WriteDataM = '0, PCPlus4M = '0, DMemRData = '0;
    logic [4:0]  RdM = '0;
    logic [3:0]  controlM = '0;
    logic        DMemAck = 1'b0;
    logic        DMemReq, DMemWE, StallM, RegWriteMH;
    logic [31:0] DMemAddr, DMemWData, ALUResultMH, ALUResultW, ReadDataW, PCPlus4W;
    logic [4:0]  RdMH, RdW;
    logic [2:0]  controlW;
    logic [15:0] StallCount;

    int n_checks = 0;
    int n_fail   = 0;

    memory_stage dut (
        .CLK(CLK), .RST(RST), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .controlM(controlM), .DMemRData(DMemRData),
        .DMemAck(DMemAck), .DMemReq(DMemReq), .DMemWE(DMemWE), .DMemAddr(DMemAddr),
        .DMemWData(DMemWData), .StallM(StallM), .ALUResultMH(ALUResultMH), .RdMH(RdMH),
        .RegWriteMH(RegWriteMH), .ALUResultW(ALUResultW), .ReadDataW(ReadDataW),
        .PCPlus4W(PCPlus4W), .RdW(RdW), .controlW(controlW), .StallCount(StallCount)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  ctrl;
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        ack;
        logic        req, we, stall;
        logic [2:0]  ctrlw;
        logic [4:0]  rdw;
        logic [31:0] aluw, readw, pc4w;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] p, input logic [4:0] r, input logic [31:0] rd,
                         input logic k);
        controlM = c; ALUResultM = a; WriteDataM = w; PCPlus4M = p;
        RdM = r; DMemRData = rd; DMemAck = k;
    endtask

    // Holds reset across one rising edge; returns at posedge+1 with reset released.
    task automatic do_reset();
        @(posedge CLK); #2 RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
    endtask

    task automatic check_w_zero(input string tag);
        check({tag, "_ctrlw"}, {29'd0, controlW}, 32'd0);
        check({tag, "_rdw"},   {27'd0, RdW}, 32'd0);
        check({tag, "_aluw"},  ALUResultW, 32'd0);
        check({tag, "_readw"}, ReadDataW, 32'd0);
        check({tag, "_pc4w"},  PCPlus4W, 32'd0);
    endtask

    initial begin
        // Model state for the random phase
        logic [3:0]  c;
        logic [31:0] a, w, p, rdat;
        logic [4:0]  r;
        logic        k, acc, ld, stall, held;
        int          stalls;
        logic [2:0]  e_ctrlw;
        logic [4:0]  e_rdw;
        logic [31:0] e_aluw, e_readw, e_pc4w;

        vecs[0] = '{4'b1000, 32'h10, 32'h0, 32'h104, 5'd5, 32'h0, 1'b0,
                    1'b0, 1'b0, 1'b0, 3'b100, 5'd5, 32'h10, 32'h0, 32'h104, 16'd0};
        vecs[1] = '{4'b1010, 32'h40, 32'h0, 32'h108, 5'd7, 32'hDEADBEEF, 1'b1,
                    1'b1, 1'b0, 1'b0, 3'b101, 5'd7, 32'h40, 32'hDEADBEEF, 32'h108, 16'd0};
        vecs[2] = '{4'b1000, 32'h55, 32'h0, 32'h10C, 5'd3, 32'h12345678, 1'b1,
                    1'b0, 1'b0, 1'b0, 3'b100, 5'd3, 32'h55, 32'h0, 32'h10C, 16'd0};
        vecs[3] = '{4'b0001, 32'h80, 32'hCAFE, 32'h110, 5'd9, 32'h0BAD0BAD, 1'b1,
                    1'b1, 1'b1, 1'b0, 3'b000, 5'd9, 32'h80, 32'h0, 32'h110, 16'd0};
        vecs[4] = '{4'b1100, 32'h3, 32'h0, 32'h114, 5'd31, 32'hAAAA5555, 1'b0,
                    1'b0, 1'b0, 1'b0, 3'b110, 5'd31, 32'h3, 32'h0, 32'h114, 16'd0};
        vecs[5] = '{4'b0011, 32'h84, 32'h77, 32'h118, 5'd2, 32'h11111111, 1'b1,
                    1'b1, 1'b1, 1'b0, 3'b001, 5'd2, 32'h84, 32'h0, 32'h118, 16'd0};
        vecs[6] = '{4'b1010, 32'h47, 32'h0, 32'h11C, 5'd4, 32'hFEEDFACE, 1'b0,
                    1'b1, 1'b0, 1'b1, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 16'd1};
        vecs[7] = '{4'b1010, 32'h47, 32'h0, 32'h11C, 5'd4, 32'hFEEDFACE, 1'b1,
                    1'b1, 1'b0, 1'b0, 3'b101, 5'd4, 32'h47, 32'hFEEDFACE, 32'h11C, 16'd1};

        // Reset state with a pending load on the inputs
        drive(4'b1010, 32'h40, 32'h0, 32'h4, 5'd1, 32'h1, 1'b0);
        #1;
        check("rst_req", {31'd0, DMemReq}, 32'd0);
        check("rst_stall", {31'd0, StallM}, 32'd0);
        check("rst_cnt", {16'd0, StallCount}, 32'd0);
        check_w_zero("rst");
        @(posedge CLK); #1;
        check("rst_edge_cnt", {16'd0, StallCount}, 32'd0);
        check_w_zero("rst_edge");
        RST = 1'b0;

        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].ctrl, vecs[i].alu, vecs[i].wd, vecs[i].pc4, vecs[i].rd,
                  vecs[i].rdata, vecs[i].ack);
            @(negedge CLK);
            check($sformatf("v%0d_req", i), {31'd0, DMemReq}, {31'd0, vecs[i].req});
            check($sformatf("v%0d_we", i), {31'd0, DMemWE}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_stall", i), {31'd0, StallM}, {31'd0, vecs[i].stall});
            check($sformatf("v%0d_addr", i), DMemAddr, vecs[i].alu);
            check($sformatf("v%0d_wdat", i), DMemWData, vecs[i].wd);
            check($sformatf("v%0d_aluh", i), ALUResultMH, vecs[i].alu);
            check($sformatf("v%0d_rdh", i), {27'd0, RdMH}, {27'd0, vecs[i].rd});
            check($sformatf("v%0d_rwh", i), {31'd0, RegWriteMH}, {31'd0, vecs[i].ctrl[3]});
            @(posedge CLK); #1;
            check($sformatf("v%0d_ctrlw", i), {29'd0, controlW}, {29'd0, vecs[i].ctrlw});
            check($sformatf("v%0d_rdw", i), {27'd0, RdW}, {27'd0, vecs[i].rdw});
            check($sformatf("v%0d_aluw", i), ALUResultW, vecs[i].aluw);
            check($sformatf("v%0d_readw", i), ReadDataW, vecs[i].readw);
            check($sformatf("v%0d_pc4w", i), PCPlus4W, vecs[i].pc4w);
            check($sformatf("v%0d_cnt", i), {16'd0, StallCount}, {16'd0, vecs[i].cnt});
        end

        // Store with three wait cycles, ack on the fourth
        do_reset();
        drive(4'b0001, 32'h200, 32'hCAFE, 32'h300, 5'd6, 32'h0, 1'b0);
        for (int k3 = 0; k3 < 3; k3++) begin
            @(negedge CLK);
            check("st_wait_req", {31'd0, DMemReq}, 32'd1);
            check("st_wait_we", {31'd0, DMemWE}, 32'd1);
            check("st_wait_stall", {31'd0, StallM}, 32'd1);
            check("st_wait_wdat", DMemWData, 32'hCAFE);
            @(posedge CLK); #1;
            check_w_zero("st_bubble");
            check("st_wait_cnt", {16'd0, StallCount}, k3 + 1);
        end
        DMemAck = 1'b1;
        @(negedge CLK);
        check("st_ack_req", {31'd0, DMemReq}, 32'd1);
        check("st_ack_we", {31'd0, DMemWE}, 32'd1);
        check("st_ack_stall", {31'd0, StallM}, 32'd0);
        @(posedge CLK); #1;
        check("st_ack_ctrlw", {29'd0, controlW}, 32'd0);
        check("st_ack_rdw", {27'd0, RdW}, 32'd6);
        check("st_ack_aluw", ALUResultW, 32'h200);
        check("st_ack_cnt", {16'd0, StallCount}, 32'd3);
        drive(4'b1000, 32'h10, 32'h0, 32'h304, 5'd5, 32'h0, 1'b0);
        @(negedge CLK);
        check("st_after_stall", {31'd0, StallM}, 32'd0);
        @(posedge CLK); #1;
        check("st_after_ctrlw", {29'd0, controlW}, 32'b100);
        check("st_after_cnt", {16'd0, StallCount}, 32'd3);

        // Reset pulsed while a load waits
        do_reset();
        drive(4'b1010, 32'h60, 32'h0, 32'h400, 5'd8, 32'h13579BDF, 1'b0);
        @(posedge CLK); @(posedge CLK); #1;
        check("rw_pre_cnt", {16'd0, StallCount}, 32'd2);
        #1 RST = 1'b1;
        #1;
        check("rw_req", {31'd0, DMemReq}, 32'd0);
        check("rw_stall", {31'd0, StallM}, 32'd0);
        check("rw_cnt", {16'd0, StallCount}, 32'd0);
        check_w_zero("rw");
        @(negedge CLK) RST = 1'b0;
        #1;
        check("rw_rel_req", {31'd0, DMemReq}, 32'd1);
        check("rw_rel_stall", {31'd0, StallM}, 32'd1);
        @(posedge CLK); #1;
        check("rw_rel_cnt", {16'd0, StallCount}, 32'd1);
        DMemAck = 1'b1;
        @(posedge CLK); #1;
        check("rw_done_readw", ReadDataW, 32'h13579BDF);
        check("rw_done_ctrlw", {29'd0, controlW}, 32'b101);
        check("rw_done_cnt", {16'd0, StallCount}, 32'd1);

        // Random traffic against the behavioural model; inputs frozen while stalled
        do_reset();
        stalls = 0;
        held   = 1'b0;
        c = 4'd0; a = '0; w = '0; p = '0; r = '0;
        for (int n = 0; n < 2000; n++) begin
            if (!held) begin
                c = 4'($urandom_range(0, 15));
                a = $urandom; w = $urandom; p = $urandom; r = 5'($urandom_range(0, 31));
            end
            rdat = $urandom;
            k    = ($urandom_range(0, 2) != 0);
            drive(c, a, w, p, r, rdat, k);
            acc   = c[0] || (c[2:1] == 2'b01);
            ld    = (c[2:1] == 2'b01) && !c[0];
            stall = acc && !k;
            @(negedge CLK);
            check("rnd_req", {31'd0, DMemReq}, {31'd0, acc});
            check("rnd_stall", {31'd0, StallM}, {31'd0, stall});
            check("rnd_we", {31'd0, DMemWE}, {31'd0, c[0]});
            if (stall) begin
                stalls++;
                e_ctrlw = 3'b000; e_rdw = 5'd0; e_aluw = 32'h0; e_readw = 32'h0; e_pc4w = 32'h0;
            end else begin
                e_ctrlw = c[3:1]; e_rdw = r; e_aluw = a; e_pc4w = p;
                e_readw = ld ? rdat : 32'h0;
            end
            held = stall;
            @(posedge CLK); #1;
            check("rnd_ctrlw", {29'd0, controlW}, {29'd0, e_ctrlw});
            check("rnd_rdw", {27'd0, RdW}, {27'd0, e_rdw});
            check("rnd_aluw", ALUResultW, e_aluw);
            check("rnd_readw", ReadDataW, e_readw);
            check("rnd_pc4w", PCPlus4W, e_pc4w);
            check("rnd_cnt", {16'd0, StallCount}, (stalls > 65535) ? 65535 : stalls);
        end

        // Saturation: hold a load without ack for 65,540 edges
        do_reset();
        drive(4'b1010, 32'h90, 32'h0, 32'h500, 5'd3, 32'h0, 1'b0);
        repeat (65534) @(posedge CLK);
        #1;
        check("sat_fffe", {16'd0, StallCount}, 32'h0000FFFE);
        @(posedge CLK); #1;
        check("sat_ffff", {16'd0, StallCount}, 32'h0000FFFF);
        repeat (5) @(posedge CLK);
        #1;
        check("sat_hold", {16'd0, StallCount}, 32'h0000FFFF);
        check("sat_stall", {31'd0, StallM}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: CLK and RST, with no other clock or reset.
REQ-002 SHALL have these ports (name, direction, width, meaning):
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-high reset
- ALUResultM  in  32  E/M ALU result; also the memory address
- WriteDataM  in  32  E/M store data
- PCPlus4M  in  32  E/M PC+4
- RdM  in  5  E/M destination register
- controlM  in  4  [0] MemWrite, [2:1] ResultSrc (00 ALU, 01 load, 10 PC+4), [3] RegWrite
- DMemRData  in  32  data memory read data
- DMemAck  in  1  data memory completion strobe
- DMemReq  out  1  data memory request
- DMemWE  out  1  write enable, qualified by DMemReq
- DMemAddr  out  32  byte address
- DMemWData  out  32  store data
- StallM  out  1  stall request to the hazard unit
- ALUResultMH  out  32  forwarding copy of ALUResultM
- RdMH  out  5  hazard copy of RdM
- RegWriteMH  out  1  hazard copy of controlM[3]
- ALUResultW, ReadDataW, PCPlus4W  out  32  M/W register outputs
- RdW  out  5  M/W destination register
- controlW  out  3  {RegWrite, ResultSrc[1:0]}
- StallCount  out  16  saturating count of stall cycles

Function
REQ-003 SHALL define access = controlM[0] | (controlM[2:1]==01), load = (controlM[2:1]==01) & ~controlM[0], and store = controlM[0].
REQ-004 SHALL drive DMemAddr = ALUResultM, DMemWData = WriteDataM and DMemWE = controlM[0] combinationally.
REQ-005 SHALL drive ALUResultMH = ALUResultM, RdMH = RdM and RegWriteMH = controlM[3] combinationally, with zero latency.
REQ-006 SHALL implement a two-state FSM:
- IDLE -> WAIT on access & ~DMemAck.
- WAIT -> IDLE on DMemAck.
- Otherwise the FSM holds its state.
REQ-007 SHALL assert DMemReq = access & ~RST in both states, so a zero-wait memory (ack in the same cycle) completes without a stall.
REQ-008 SHALL assert StallM = access & ~DMemAck & ~RST combinationally.
REQ-009 SHALL ignore DMemAck while access=0, leaving the FSM and the outputs unaffected.
REQ-010 SHALL rely on the upstream stages holding ALUResultM, WriteDataM, PCPlus4M, RdM and controlM stable while StallM=1; this block SHALL NOT re-latch them.
REQ-011 SHALL update the M/W register on a rising CLK edge with StallM=0 as follows:
- ALUResultW <= ALUResultM, PCPlus4W <= PCPlus4M, RdW <= RdM, controlW <= controlM[3:1].
- ReadDataW <= DMemRData if load, else 32'h0.
REQ-012 SHALL insert a bubble on a rising edge with StallM=1: controlW <= 3'b000, RdW <= 0, ALUResultW/ReadDataW/PCPlus4W <= 0.
REQ-013 SHALL issue exactly one completed memory transaction per M-stage instruction; with DMemReq held across WAIT, the transaction completes on the first DMemAck.
REQ-014 SHALL increment StallCount by 1 on every rising edge with StallM=1, saturate at 16'hFFFF and never wrap.
REQ-015 SHALL perform no alignment, size or sign handling: word accesses only; ALUResultM[1:0] is passed through unchanged.

Reset
REQ-016 SHALL, while RST=1, asynchronously force state=IDLE, all M/W register outputs to 0 and StallCount to 0; DMemReq=0 and StallM=0 regardless of the inputs.
REQ-017 SHALL, on reset asserted in WAIT, abandon the transaction; after RST falls, a still-present access SHALL issue a fresh request.
REQ-018 SHALL resume normal operation on the first rising CLK edge after RST deasserts.

Verification
REQ-019 Bench SHALL cover an ALU op: controlM=4'b1000, ALUResultM=32'h10, RdM=5 -> DMemReq=0, StallM=0; next edge ALUResultW=32'h10, RdW=5, controlW=3'b100.
REQ-020 Bench SHALL cover a zero-wait load: controlM=4'b1010, ALUResultM=32'h40, DMemAck=1 same cycle, DMemRData=32'hDEADBEEF -> DMemReq=1, StallM=0; next edge ReadDataW=32'hDEADBEEF, controlW=3'b101, StallCount=0.
REQ-021 Bench SHALL cover a 3-wait store: controlM=4'b0001, WriteDataM=32'hCAFE, ack on the 4th cycle -> DMemReq=1, DMemWE=1 for 4 cycles; StallM=1 for 3 cycles; 3 bubbles (controlW=0); StallCount=3; on the ack edge controlW=3'b000 and the FSM returns to IDLE.
REQ-022 Bench SHALL cover reset in WAIT: a load in WAIT with RST pulsed high mid-cycle -> DMemReq, StallM and the outputs go to 0 immediately; after release with the load still present, DMemReq=1 again and StallCount restarts from 0.
REQ-023 Bench SHALL cover a spurious ack: DMemAck=1 with controlM=4'b1000 -> no state change, StallM=0, normal W update.
REQ-024 Bench SHALL cover saturation: preload via 65,540 stall cycles -> StallCount=16'hFFFF and holding.
